// File: rtl/dlx_pkg.sv
// Shared DLX pipeline constants and types used by the write-back stage.
package dlx_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RA_W  = 5;

  typedef logic [RA_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 architectural register file: one write port, two raw read ports.
// Register 0 has no storage and reads as zero; storage clears on async reset.
module regfile_2r1w
  import dlx_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  input  reg_addr_t raddr_a,
  input  reg_addr_t raddr_b,
  output word_t     rdata_a,
  output word_t     rdata_b
);

  word_t mem [1:NREGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/wb_stage.sv
// DLX write-back stage: result select, register commit, bypassed decode reads,
// execute forwarding tap. Retirement counters are built only with WB_RETIRE_CNT_EN.
module wb_stage
  import dlx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  word_t       dout_mem,
  input  word_t       result_mem,
  input  logic        MemtoReg_mem,
  input  logic        RegWrite_mem,
  input  reg_addr_t   towrite_mem,
  input  logic        wb_stall,
  input  reg_addr_t   rs_addr,
  input  reg_addr_t   rt_addr,
  output word_t       rs_data,
  output word_t       rt_data,
  output logic        fwd_valid,
  output reg_addr_t   fwd_reg,
  output word_t       fwd_data,
  output logic [31:0] retired_cnt,
  output logic [31:0] load_cnt
);

  word_t wb_data;
  logic  commit;
  word_t rs_raw;
  word_t rt_raw;

  assign wb_data = MemtoReg_mem ? dout_mem : result_mem;
  assign commit  = RegWrite_mem & ~wb_stall & (towrite_mem != '0);

  regfile_2r1w u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (commit),
    .waddr   (towrite_mem),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (rs_raw),
    .rdata_b (rt_raw)
  );

  // Same-cycle bypass so decode sees the value being committed right now.
  always_comb begin
    rs_data = rs_raw;
    rt_data = rt_raw;
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (commit && (rs_addr == towrite_mem)) begin
      rs_data = wb_data;
    end
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (commit && (rt_addr == towrite_mem)) begin
      rt_data = wb_data;
    end
  end

  assign fwd_valid = commit;
  assign fwd_reg   = towrite_mem;
  assign fwd_data  = wb_data;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] load_q;

  // Free-running wrap-around counters of committed writes and committed loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      load_q    <= '0;
    end else if (commit) begin
      retired_q <= retired_q + 32'd1;
      if (MemtoReg_mem) begin
        load_q <= load_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_q;
  assign load_cnt    = load_q;
`else
  assign retired_cnt = '0;
  assign load_cnt    = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a driver pushes expected outputs from a
// behavioural register-file model; a monitor pops and compares each cycle.
module tb_wb_stage;
  import dlx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  word_t       dout_mem, result_mem;
  logic        MemtoReg_mem, RegWrite_mem, wb_stall;
  reg_addr_t   towrite_mem, rs_addr, rt_addr;
  word_t       rs_data, rt_data, fwd_data;
  logic        fwd_valid;
  reg_addr_t   fwd_reg;
  logic [31:0] retired_cnt, load_cnt;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .dout_mem(dout_mem), .result_mem(result_mem),
    .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
    .towrite_mem(towrite_mem), .wb_stall(wb_stall), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .retired_cnt(retired_cnt), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs, rt, fdata, ret, ld;
    logic        fvalid;
    logic [4:0]  freg;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_regs [0:31];
  logic [31:0] ref_retired, ref_loads;
  int          checks = 0;
  int          errors = 0;
  bit          done = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle shortly after posedge, records the expected outputs,
  // then advances the model as if the following posedge has happened.
  task automatic apply_stimulus(input logic rst, input logic rw, input logic m2r,
                                input logic stall, input logic [4:0] rd,
                                input logic [31:0] dout, input logic [31:0] res,
                                input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    logic [31:0] wb;
    bit commit;
    @(posedge clk);
    #2;
    rst_n = rst; RegWrite_mem = rw; MemtoReg_mem = m2r; wb_stall = stall;
    towrite_mem = rd; dout_mem = dout; result_mem = res; rs_addr = ra; rt_addr = rb;
    if (!rst) begin
      foreach (ref_regs[i]) ref_regs[i] = '0;
      ref_retired = 0;
      ref_loads = 0;
    end
    wb = m2r ? dout : res;
    commit = rw && !stall && (rd != 0);
    e.rs = (ra == 0) ? 32'd0 : (commit && ra == rd) ? wb : ref_regs[ra];
    e.rt = (rb == 0) ? 32'd0 : (commit && rb == rd) ? wb : ref_regs[rb];
    e.fvalid = commit;
    e.freg = rd;
    e.fdata = wb;
`ifdef WB_RETIRE_CNT_EN
    e.ret = ref_retired;
    e.ld  = ref_loads;
`else
    e.ret = 0;
    e.ld  = 0;
`endif
    sb_q.push_back(e);
    if (rst && commit) begin
      ref_regs[rd] = wb;
      ref_retired = ref_retired + 1;
      if (m2r) ref_loads = ref_loads + 1;
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output("rs_data", rs_data, e.rs);
        check_output("rt_data", rt_data, e.rt);
        check_output("fwd_valid", {31'd0, fwd_valid}, {31'd0, e.fvalid});
        check_output("fwd_reg", {27'd0, fwd_reg}, {27'd0, e.freg});
        check_output("fwd_data", fwd_data, e.fdata);
        check_output("retired_cnt", retired_cnt, e.ret);
        check_output("load_cnt", load_cnt, e.ld);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; RegWrite_mem = 0; MemtoReg_mem = 0; wb_stall = 0;
    towrite_mem = 0; dout_mem = 0; result_mem = 0; rs_addr = 0; rt_addr = 0;
    foreach (ref_regs[i]) ref_regs[i] = '0;
    ref_retired = 0;
    ref_loads = 0;

    // Held in reset: commit request is visible on fwd_* but not stored.
    apply_stimulus(0, 1, 0, 0, 5'd4, 32'h0, 32'hAAAA5555, 5'd4, 5'd0);
    apply_stimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd5);
    apply_stimulus(1, 1, 0, 0, 5'd5, 32'h0, 32'h00001234, 5'd5, 5'd4);
    apply_stimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
    // Mid-run reset clears r5 and the counters asynchronously.
    apply_stimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
    apply_stimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);

    apply_stimulus(1, 1, 0, 0, 5'd7, 32'h0, 32'hDEADBEEF, 5'd7, 5'd7);
    apply_stimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);
    apply_stimulus(1, 1, 1, 0, 5'd3, 32'hFFFFFF80, 32'h00000100, 5'd3, 5'd7);
    apply_stimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3);
    apply_stimulus(1, 1, 0, 0, 5'd0, 32'h0, 32'h00000055, 5'd0, 5'd0);
    apply_stimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd3);
    apply_stimulus(1, 1, 0, 0, 5'd9, 32'h0, 32'h00000011, 5'd1, 5'd2);
    apply_stimulus(1, 1, 0, 1, 5'd9, 32'h0, 32'h00000077, 5'd9, 5'd9);
    apply_stimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd7);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd, ra, rb;
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ra = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
      apply_stimulus(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 4) == 0), rd, $urandom, $urandom, ra, rb);
    end

`ifdef WB_RETIRE_CNT_EN
    // Preload the retirement counter just below wrap, then commit once.
    @(posedge clk);
    #1;
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    ref_retired = 32'hFFFFFFFF;
    apply_stimulus(1, 1, 0, 0, 5'd12, 32'h0, 32'h00C0FFEE, 5'd12, 5'd0);
    apply_stimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd12);
`endif

    @(negedge clk);
    @(negedge clk);
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
